// File: rtl/mem_pkg.sv
// mem_pkg: shared state encoding and default addresses for the data-memory responder
package mem_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} mem_state_t;
    localparam logic [31:0] DEFAULT_LED_ADDR = 32'hFFFF_FF00;
endpackage

// File: rtl/ram_be.sv
// ram_be: word-addressed RAM with per-byte-lane writes and a registered read port
module ram_be #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [3:0]    byteena,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   q
);
    logic [3:0][7:0] mem [DEPTH_WORDS];
    // q only moves on reads, so it holds the last loaded word across stores
    always_ff @(posedge clk) begin
        if (en && we)
            for (int i = 0; i < 4; i++)
                if (byteena[i]) mem[addr][i] <= wdata[8*i +: 8];
        if (en && !we) q <= mem[addr];
    end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: single-outstanding load/store responder with wait stretching,
// backing a byte-lane RAM and one memory-mapped LED register.
module mem_responder
    import mem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] LED_ADDR    = DEFAULT_LED_ADDR
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  byteena,
    output logic        memWait,
    output logic [31:0] rdata,
    output logic        err,
    output logic [7:0]  LED
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = LATENCY > 0 ? $clog2(LATENCY + 1) : 1;
    localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH_WORDS);

    mem_state_t    state, state_n;
    logic [CW-1:0] cnt;
    logic          we_q, err_q, sel_ram, access, hit_led, hit_ram;
    logic [31:0]   addr_q, wdata_q, rdata_q, ram_q, a;
    logic [32:0]   off;
    logic [3:0]    be_q;
    logic [7:0]    led_q;

    // 33-bit offset: bit 32 set means the address lies below BASE_ADDR
    assign a       = addr_q & 32'hFFFF_FFFC;
    assign off     = {1'b0, a} - {1'b0, BASE_ADDR};
    assign hit_led = a == (LED_ADDR & 32'hFFFF_FFFC);
    assign hit_ram = !hit_led && !off[32] && off[31:0] < RAM_BYTES;

    always_ff @(posedge CLK or posedge RST)
        if (RST) state <= IDLE;
        else     state <= state_n;

    always_comb
        state_n = state == IDLE ? (req ? BUSY : IDLE) :
                  state == BUSY ? (cnt == '0 ? DONE : BUSY) : IDLE;

    always_comb begin
        memWait = (state == IDLE && req) || state == BUSY;
        access  = state == BUSY && cnt == '0;
    end

    always_ff @(posedge CLK or posedge RST)
        if (RST) begin
            cnt     <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            err_q   <= 1'b0;
            led_q   <= '0;
            rdata_q <= '0;
            sel_ram <= 1'b0;
        end else if (state == IDLE && req) begin
            cnt     <= CW'(LATENCY);
            we_q    <= we;
            addr_q  <= addr;
            wdata_q <= wdata;
            be_q    <= byteena;
            err_q   <= 1'b0;
        end else if (state == BUSY && cnt != '0) begin
            cnt <= cnt - CW'(1);
        end else if (access) begin
            err_q <= !hit_led && !hit_ram;
            if (hit_led && we_q && be_q[0]) led_q <= wdata_q[7:0];
            if (!we_q) begin
                sel_ram <= hit_ram;
                rdata_q <= hit_led ? {24'b0, led_q} : '0;
            end
        end

    ram_be #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_ram (
        .clk     (CLK),
        .en      (access && hit_ram),
        .we      (we_q),
        .byteena (be_q),
        .addr    (off[AW+1:2]),
        .wdata   (wdata_q),
        .q       (ram_q)
    );

    assign rdata = sel_ram ? ram_q : rdata_q;
    assign err   = err_q;
    assign LED   = led_q;
endmodule
